moore_seq_driver: RTL and testbench

Sequencer for the two-bit Moore sequence-detector FSM in lab5. On a start request it synchronously resets the FSM, serially drives a WIDTH-bit stimulus word onto the FSM's X input MSB-first, and collects the Moore output Z after every bit into a parallel response word. It enables the FSM's tri-state state bus only while a run is active and captures the FSM's final state. It sits between a parallel host (switches/testbench) and one FSM instance.

---
 rtl/moore_seq_driver.sv | 115 +++++++++++
 tb/tb_moore_seq_driver.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/moore_seq_driver.sv
// Sequencer for the lab5 two-bit Moore detector: resets the FSM, shifts a stimulus
// word out MSB-first on X, and gathers the Moore response Z into a parallel word.
module moore_seq_driver #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             Ck,
   input  logic             Reset,
   input  logic             Start,
   input  logic [WIDTH-1:0] DataIn,
   input  logic             Z,
   input  logic [1:0]       outState,
   output logic             FsmReset,
   output logic             X,
   output logic             OC,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] ZOut,
   output logic [1:0]       FinalState
);

   localparam int unsigned CntW = $clog2(WIDTH + 1);
   localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

   typedef enum logic [2:0] {
      stIdle,
      stInit,
      stRun,
      stTail,
      stDone
   } state_t;

   state_t           state;
   state_t           nextState;
   logic [WIDTH-1:0] shiftReg;
   logic [CntW-1:0]  bitCnt;

   always_ff @(posedge Ck) begin
      if (Reset) begin
         state      <= stIdle;
         shiftReg   <= '0;
         bitCnt     <= '0;
         ZOut       <= '0;
         FinalState <= '0;
      end else begin
         state <= nextState;
         case (state)
            stIdle: begin
               if (Start) begin
                  shiftReg <= DataIn;
                  ZOut     <= '0;
               end
            end
            stInit: begin
               bitCnt <= '0;
            end
            stRun: begin
               shiftReg <= {shiftReg[WIDTH-2:0], 1'b0};
               bitCnt   <= bitCnt + 1'b1;
               // First RUN cycle still shows Z of the freshly reset S0, not a bit response.
               if (bitCnt != '0) begin
                  ZOut <= {ZOut[WIDTH-2:0], Z};
               end
            end
            stTail: begin
               ZOut       <= {ZOut[WIDTH-2:0], Z};
               FinalState <= outState;
            end
            default: begin
            end
         endcase
      end
   end

   always_comb begin
      nextState = state;
      FsmReset  = 1'b0;
      X         = 1'b0;
      OC        = 1'b0;
      Busy      = 1'b0;
      Done      = 1'b0;
      case (state)
         stIdle: begin
            if (Start) begin
               nextState = stInit;
            end
         end
         stInit: begin
            FsmReset  = 1'b1;
            Busy      = 1'b1;
            nextState = stRun;
         end
         stRun: begin
            X    = shiftReg[WIDTH-1];
            OC   = 1'b1;
            Busy = 1'b1;
            if (bitCnt == LastBit) begin
               nextState = stTail;
            end
         end
         stTail: begin
            OC        = 1'b1;
            Busy      = 1'b1;
            nextState = stDone;
         end
         stDone: begin
            Done      = 1'b1;
            nextState = stIdle;
         end
         default: begin
            nextState = stIdle;
         end
      endcase
   end

endmodule

// File: tb/tb_moore_seq_driver.sv
// Directed bench for moore_seq_driver with a behavioural model of the lab5 Moore FSM
// (S0:0->S3,1->S1  S1:0->S0,1->S2  S2:0->S1,1->S2  S3:0->S2,1->S1; Z=1 in S1,S3).
module tb_moore_seq_driver;

   localparam int W = 8;

   logic         Ck = 1'b0;
   logic         Reset;
   logic         Start;
   logic [W-1:0] DataIn;
   wire          Z;
   wire  [1:0]   outState;
   logic         FsmReset;
   logic         X;
   logic         OC;
   logic         Busy;
   logic         Done;
   logic [W-1:0] ZOut;
   logic [1:0]   FinalState;

   logic [1:0]   fsmState = 2'b00;
   logic         prevDone = 1'b0;
   int           total = 0;
   int           bad = 0;

   always #5 Ck = ~Ck;

   moore_seq_driver #(.WIDTH(W)) dut (
      .Ck(Ck),
      .Reset(Reset),
      .Start(Start),
      .DataIn(DataIn),
      .Z(Z),
      .outState(outState),
      .FsmReset(FsmReset),
      .X(X),
      .OC(OC),
      .Busy(Busy),
      .Done(Done),
      .ZOut(ZOut),
      .FinalState(FinalState)
   );

   always @(posedge Ck) begin
      if (FsmReset) fsmState <= 2'b00;
      else begin
         case ({fsmState, X})
            3'b00_0: fsmState <= 2'b11;
            3'b00_1: fsmState <= 2'b01;
            3'b01_0: fsmState <= 2'b00;
            3'b01_1: fsmState <= 2'b10;
            3'b10_0: fsmState <= 2'b01;
            3'b10_1: fsmState <= 2'b10;
            3'b11_0: fsmState <= 2'b10;
            default: fsmState <= 2'b01;
         endcase
      end
   end

   assign Z        = fsmState[0];
   assign outState = OC ? fsmState : 2'bzz;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   always @(negedge Ck) begin
      checkVal("busyDone", {31'b0, Busy & Done}, 32'd0);
      checkVal("doneWidth", {31'b0, prevDone & Done}, 32'd0);
      prevDone = Done;
   end

   // Caller is positioned at a negedge with the DUT in IDLE; cycle 1 is INIT.
   task automatic runOnce(input logic [W-1:0] data, input bit hold, input bit disturb,
                          output int doneCyc, output logic [31:0] rstMask,
                          output logic [31:0] ocMask, output logic [W-1:0] xs,
                          output logic xOff, output logic [W-1:0] zAtInit);
      int c;
      Start   = 1'b1;
      DataIn  = data;
      doneCyc = -1;
      rstMask = '0;
      ocMask  = '0;
      xs      = '0;
      xOff    = 1'b0;
      zAtInit = '1;
      c       = 0;
      while (doneCyc < 0 && c < 30) begin
         @(negedge Ck);
         c++;
         rstMask[c] = FsmReset;
         ocMask[c]  = OC;
         if (c >= 2 && c <= W + 1) xs = {xs[W-2:0], X};
         else xOff = xOff | X;
         if (c == 1) zAtInit = ZOut;
         if (Done) doneCyc = c;
         if (!hold) Start = 1'b0;
         if (disturb && c >= 3 && c <= 8) begin
            Start  = c[0];
            DataIn = DataIn ^ 8'hA5;
         end
      end
   endtask

   task automatic checkResetOutputs(input string tag);
      checkVal({tag, "_ctl"}, {27'b0, Busy, Done, OC, X, FsmReset}, 32'd0);
      checkVal({tag, "_zout"}, {24'b0, ZOut}, 32'd0);
      checkVal({tag, "_fs"}, {30'b0, FinalState}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int           dc;
      logic [31:0]  rm, om;
      logic [W-1:0] xs, zi;
      logic         xo;
      int           activity;

      Reset  = 1'b1;
      Start  = 1'b0;
      DataIn = '0;
      repeat (2) @(negedge Ck);
      checkResetOutputs("reset");
      Reset = 1'b0;
      @(negedge Ck);

      runOnce(8'b11110000, 1'b0, 1'b0, dc, rm, om, xs, xo, zi);
      checkVal("t1_doneCyc", dc, 32'd11);
      checkVal("t1_zout", {24'b0, ZOut}, 32'b10001010);
      checkVal("t1_fs", {30'b0, FinalState}, 32'b10);
      checkVal("t1_xstream", {24'b0, xs}, 32'hF0);
      checkVal("t1_xoff", {31'b0, xo}, 32'd0);
      repeat (3) @(negedge Ck);
      checkVal("hold_zout", {24'b0, ZOut}, 32'b10001010);
      checkVal("hold_fs", {30'b0, FinalState}, 32'b10);

      runOnce(8'h00, 1'b0, 1'b0, dc, rm, om, xs, xo, zi);
      checkVal("t2_clearAtInit", {24'b0, zi}, 32'd0);
      checkVal("t2_doneCyc", dc, 32'd11);
      checkVal("t2_fsmResetMask", rm, 32'h0000_0002);
      checkVal("t2_ocMask", om, 32'h0000_07FC);
      checkVal("t2_zout", {24'b0, ZOut}, 32'b10101010);
      checkVal("t2_fs", {30'b0, FinalState}, 32'b00);
      checkVal("t2_xstream", {24'b0, xs}, 32'h00);
      @(negedge Ck);

      runOnce(8'hFF, 1'b1, 1'b0, dc, rm, om, xs, xo, zi);
      checkVal("t3a_doneCyc", dc, 32'd11);
      checkVal("t3a_zout", {24'b0, ZOut}, 32'b10000000);
      checkVal("t3a_fs", {30'b0, FinalState}, 32'b10);
      DataIn = 8'b01010101;
      @(negedge Ck);
      checkVal("t3_idleGap", {30'b0, Busy, FsmReset}, 32'd0);
      runOnce(8'b01010101, 1'b0, 1'b0, dc, rm, om, xs, xo, zi);
      checkVal("t3b_doneCyc", dc, 32'd11);
      checkVal("t3b_fsmResetMask", rm, 32'h0000_0002);
      checkVal("t3b_zout", {24'b0, ZOut}, 32'b11010101);
      checkVal("t3b_fs", {30'b0, FinalState}, 32'b01);
      checkVal("t3b_xstream", {24'b0, xs}, 32'h55);
      @(negedge Ck);

      runOnce(8'b11110000, 1'b0, 1'b1, dc, rm, om, xs, xo, zi);
      Start = 1'b0;
      checkVal("t4_doneCyc", dc, 32'd11);
      checkVal("t4_zout", {24'b0, ZOut}, 32'b10001010);
      checkVal("t4_fs", {30'b0, FinalState}, 32'b10);
      checkVal("t4_xstream", {24'b0, xs}, 32'hF0);
      repeat (2) @(negedge Ck);
      checkVal("t4_noRerun", {31'b0, Busy}, 32'd0);

      Start  = 1'b1;
      DataIn = 8'h00;
      @(negedge Ck);
      Start = 1'b0;
      repeat (4) @(negedge Ck);
      Reset = 1'b1;
      @(negedge Ck);
      checkResetOutputs("midReset");
      Reset    = 1'b0;
      activity = 0;
      repeat (15) begin
         @(negedge Ck);
         if (Done || Busy) activity++;
      end
      checkVal("t5_noDone", activity, 32'd0);
      runOnce(8'h00, 1'b0, 1'b0, dc, rm, om, xs, xo, zi);
      checkVal("t5_doneCyc", dc, 32'd11);
      checkVal("t5_zout", {24'b0, ZOut}, 32'b10101010);
      checkVal("t5_fs", {30'b0, FinalState}, 32'b00);
      @(negedge Ck);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
